// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_direct_pkg;

  typedef enum logic {
    ICACHE_IDLE = 1'b0,
    ICACHE_MISS = 1'b1
  } icache_state_e;

  localparam int DEFAULT_INDEX_BITS = 6;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read, synchronous write.
module icache_array #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid_bits;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  assign rd_valid = valid_bits[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_bits <= '0;
    end else if (wr_en) begin
      valid_bits[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until the valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: 1-cycle hits, single-word fill on miss.
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        if_fetch_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        if_inst_valid,
  output logic [31:0] if_inst,
  output logic        fetch_enable,
  output logic [31:0] inst_addr,
  input  logic        i_cache_valid,
  input  logic [31:0] i_cache_data
);

  localparam int TAG_BITS = 30 - INDEX_BITS;

  icache_state_e state, state_n;
  logic          drop, drop_n;
  logic [29:0]   miss_pc, miss_pc_n;
  logic          if_inst_valid_n;
  logic [31:0]   if_inst_n;
  logic          fetch_enable_n;
  logic [31:0]   inst_addr_n;
  logic          fill;

  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [31:0]         rd_data;
  logic                hit;
  logic                unused_pc_bits;

  assign unused_pc_bits = ^if_pc[1:0];

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (if_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill && rdy && !rst),
    .wr_index (miss_pc[INDEX_BITS-1:0]),
    .wr_tag   (miss_pc[29:INDEX_BITS]),
    .wr_data  (i_cache_data)
  );

  assign hit      = rd_valid && (rd_tag == if_pc[31:INDEX_BITS+2]);
  assign if_ready = (state == ICACHE_IDLE);

  always_comb begin
    state_n         = state;
    drop_n          = drop;
    miss_pc_n       = miss_pc;
    if_inst_valid_n = 1'b0;
    if_inst_n       = if_inst;
    fetch_enable_n  = fetch_enable;
    inst_addr_n     = inst_addr;
    fill            = 1'b0;
    unique case (state)
      ICACHE_IDLE: begin
        if (if_fetch_req && !clear) begin
          if (hit) begin
            if_inst_valid_n = 1'b1;
            if_inst_n       = rd_data;
          end else begin
            miss_pc_n      = if_pc[31:2];
            fetch_enable_n = 1'b1;
            inst_addr_n    = if_pc;
            drop_n         = 1'b0;
            state_n        = ICACHE_MISS;
          end
        end
      end
      ICACHE_MISS: begin
        if (clear) drop_n = 1'b1;
        // The controller cannot abort, so the line is filled even when delivery is dropped.
        if (i_cache_valid) begin
          fill           = 1'b1;
          fetch_enable_n = 1'b0;
          inst_addr_n    = '0;
          if (!drop && !clear) begin
            if_inst_valid_n = 1'b1;
            if_inst_n       = i_cache_data;
          end
          state_n = ICACHE_IDLE;
        end
      end
      default: state_n = ICACHE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ICACHE_IDLE;
      drop          <= 1'b0;
      miss_pc       <= '0;
      if_inst_valid <= 1'b0;
      if_inst       <= '0;
      fetch_enable  <= 1'b0;
      inst_addr     <= '0;
    end else if (rdy) begin
      state         <= state_n;
      drop          <= drop_n;
      miss_pc       <= miss_pc_n;
      if_inst_valid <= if_inst_valid_n;
      if_inst       <= if_inst_n;
      fetch_enable  <= fetch_enable_n;
      inst_addr     <= inst_addr_n;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct with a memory-controller model and an expected-word scoreboard.
module tb_icache_direct;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        if_fetch_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic        if_inst_valid;
  logic [31:0] if_inst;
  logic        fetch_enable;
  logic [31:0] inst_addr;
  logic        i_cache_valid = 1'b0;
  logic [31:0] i_cache_data = '0;

  int passed = 0;
  int total = 0;
  int fetch_count = 0;
  int mem_delay = 6;
  int fc_before;
  logic [31:0] exp_q[$];

  icache_direct #(.INDEX_BITS(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .clear         (clear),
    .if_fetch_req  (if_fetch_req),
    .if_pc         (if_pc),
    .if_ready      (if_ready),
    .if_inst_valid (if_inst_valid),
    .if_inst       (if_inst),
    .fetch_enable  (fetch_enable),
    .inst_addr     (inst_addr),
    .i_cache_valid (i_cache_valid),
    .i_cache_data  (i_cache_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0000_0113;
      32'h0000_0020: return 32'hDEAD_BEEF;
      default:       return {addr[15:0], ~addr[15:0]};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Drive one request for a cycle; a hit must pulse if_inst_valid, a miss must raise fetch_enable.
  task automatic applyStimulus(input logic [31:0] pc, input logic expect_miss,
                               input logic deliver, input logic clr);
    if_fetch_req = 1'b1;
    if_pc        = pc;
    clear        = clr;
    if (deliver) exp_q.push_back(mem_word(pc));
    @(negedge clk);
    if_fetch_req = 1'b0;
    clear        = 1'b0;
    checkOutput("fetch_enable_after_req", {31'b0, fetch_enable}, {31'b0, expect_miss});
    if (expect_miss) checkOutput("inst_addr_after_req", inst_addr, pc);
    else checkOutput("if_inst_valid_after_req", {31'b0, if_inst_valid}, {31'b0, !clr});
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget && !if_ready; i++) @(negedge clk);
    checkOutput("idle_within_budget", {31'b0, if_ready}, 32'd1);
  endtask

  // Memory-controller model: samples fetch_enable only when idle, answers after mem_delay cycles.
  initial begin
    bit busy = 1'b0;
    int cnt = 0;
    logic [31:0] addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
        i_cache_valid = 1'b0;
      end else if (rdy) begin
        if (i_cache_valid) begin
          i_cache_valid = 1'b0;
          busy = 1'b0;
        end else if (!busy && fetch_enable) begin
          busy = 1'b1;
          addr = inst_addr;
          cnt = mem_delay;
          fetch_count++;
        end else if (busy) begin
          if (cnt == 0) begin
            i_cache_valid = 1'b1;
            i_cache_data  = mem_word(addr);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Scoreboard: every delivered instruction must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rdy && if_inst_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_if_inst_valid", {31'b0, if_inst_valid}, 32'd0);
        else checkOutput("if_inst", if_inst, exp_q.pop_front());
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_if_ready", {31'b0, if_ready}, 32'd1);
    checkOutput("reset_fetch_enable", {31'b0, fetch_enable}, 32'd0);
    checkOutput("reset_inst_addr", inst_addr, 32'd0);
    checkOutput("reset_if_inst_valid", {31'b0, if_inst_valid}, 32'd0);
    checkOutput("reset_if_inst", if_inst, 32'd0);

    $display("[TB] cold miss on 0x0");
    applyStimulus(32'h0, 1'b1, 1'b1, 1'b0);
    waitIdle(100);
    checkOutput("fill_fetch_enable_low", {31'b0, fetch_enable}, 32'd0);
    checkOutput("fill_if_inst_valid", {31'b0, if_inst_valid}, 32'd1);
    checkOutput("fill_inst_addr_cleared", inst_addr, 32'd0);

    $display("[TB] back-to-back hits");
    applyStimulus(32'h4, 1'b1, 1'b1, 1'b0);
    waitIdle(100);
    @(negedge clk);
    fc_before = fetch_count;
    applyStimulus(32'h0, 1'b0, 1'b1, 1'b0);
    applyStimulus(32'h4, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("hits_no_fetch", fetch_count, fc_before);

    $display("[TB] clear beats request in IDLE");
    applyStimulus(32'h0, 1'b0, 1'b0, 1'b1);

    $display("[TB] index conflict");
    applyStimulus(32'h10, 1'b1, 1'b1, 1'b0);
    waitIdle(100);
    applyStimulus(32'h110, 1'b1, 1'b1, 1'b0);
    waitIdle(100);
    applyStimulus(32'h10, 1'b1, 1'b1, 1'b0);
    waitIdle(100);

    $display("[TB] clear during miss");
    applyStimulus(32'h20, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    waitIdle(100);
    checkOutput("dropped_no_valid", {31'b0, if_inst_valid}, 32'd0);
    applyStimulus(32'h20, 1'b0, 1'b1, 1'b0);

    $display("[TB] slow controller with rdy stall");
    mem_delay = 20;
    fc_before = fetch_count;
    applyStimulus(32'h40, 1'b1, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    rdy   = 1'b0;
    clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_fetch_enable", {31'b0, fetch_enable}, 32'd1);
      checkOutput("stall_if_ready", {31'b0, if_ready}, 32'd0);
    end
    rdy   = 1'b1;
    clear = 1'b0;
    waitIdle(100);
    checkOutput("slow_if_inst_valid", {31'b0, if_inst_valid}, 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("slow_single_fetch", fetch_count, fc_before + 1);
    checkOutput("slow_fetch_enable_low", {31'b0, fetch_enable}, 32'd0);
    mem_delay = 6;

    $display("[TB] reset during miss");
    applyStimulus(32'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_miss_fetch_enable", {31'b0, fetch_enable}, 32'd0);
    checkOutput("rst_miss_if_ready", {31'b0, if_ready}, 32'd1);
    checkOutput("rst_miss_inst_addr", inst_addr, 32'd0);
    applyStimulus(32'h0, 1'b1, 1'b1, 1'b0);
    waitIdle(100);
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
